// File: rtl/misr_sig_checker.sv
// MISR response compactor: folds IN_W response bits per valid beat into a WIDTH-bit
// signature over a programmed window, then checks it against a golden value.
// Optional idle watchdog enabled by defining CHK_TIMEOUT_EN.
module misr_sig_checker #(
  parameter int                WIDTH = 6,
  parameter int                IN_W  = 3,
  parameter logic [WIDTH-1:0]  TAPS  = 6'b110000,
  parameter logic [WIDTH-1:0]  SEED  = 6'b000001,
  parameter int                WIN_W = 8
`ifdef CHK_TIMEOUT_EN
  , parameter int              TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [WIDTH-1:0] exp_sig,
  input  logic             din_valid,
  input  logic [IN_W-1:0]  din,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig,
  output logic [WIN_W-1:0] beats
`ifdef CHK_TIMEOUT_EN
  , output logic           timeout
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [WIN_W-1:0] win_len_l;
  logic [WIDTH-1:0] exp_l;

  // Shift left, feed tap parity into bit 0, then XOR the zero-extended response in.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [IN_W-1:0]  d);
    logic [WIDTH-1:0] d_ext;
    d_ext = WIDTH'(d);
    return {s[WIDTH-2:0], ^(s & TAPS)} ^ d_ext;
  endfunction

`ifdef CHK_TIMEOUT_EN
  localparam int ICW = $clog2(TIMEOUT + 1);
  logic [ICW-1:0] idle_cnt;
  logic           tmo_hit;
  logic           forced_fail;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // End of window is detected from the registered beat count, so the
  // verdict trails the last accepted beat by two edges.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
`ifdef CHK_TIMEOUT_EN
    tmo_hit    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) state_next = (win_len == {WIN_W{1'b0}}) ? CHECK : RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (beats == win_len_l) begin
          state_next = CHECK;
        end else if (din_valid) begin
          accept = 1'b1;
`ifdef CHK_TIMEOUT_EN
        end else if (idle_cnt == ICW'(TIMEOUT - 1)) begin
          state_next = CHECK;
          tmo_hit    = 1'b1;
`endif
        end else begin
          state_next = RUN;
        end
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig       <= SEED;
      beats     <= {WIN_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      win_len_l <= {WIN_W{1'b0}};
      exp_l     <= {WIDTH{1'b0}};
`ifdef CHK_TIMEOUT_EN
      idle_cnt    <= {ICW{1'b0}};
      forced_fail <= 1'b0;
      timeout     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            sig       <= SEED;
            beats     <= {WIN_W{1'b0}};
            win_len_l <= win_len;
            exp_l     <= exp_sig;
            pass      <= 1'b0;
`ifdef CHK_TIMEOUT_EN
            idle_cnt    <= {ICW{1'b0}};
            forced_fail <= 1'b0;
            timeout     <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            sig   <= misr_step(sig, din);
            beats <= beats + 1'b1;
`ifdef CHK_TIMEOUT_EN
            idle_cnt <= {ICW{1'b0}};
          end else if (tmo_hit) begin
            forced_fail <= 1'b1;
          end else if (!din_valid) begin
            idle_cnt <= idle_cnt + 1'b1;
`endif
          end
        end
        CHECK: begin
          done <= 1'b1;
`ifdef CHK_TIMEOUT_EN
          pass    <= (sig == exp_l) && !forced_fail;
          timeout <= forced_fail;
`else
          pass    <= (sig == exp_l);
`endif
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
